// File: rtl/reaction_pkg.sv
// rtl/reaction_pkg.sv - shared types and constants for the reaction-time trial scheduler
package reaction_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_DELAY,
        ST_GO,
        ST_CAPTURE,
        ST_ERROR,
        ST_SUMMARY
    } state_e;

    localparam logic [15:0] LFSR_SEED      = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS      = 16'hB400;
    localparam int          TIME_W_DEFAULT = 14;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reaction_lfsr.sv
// rtl/reaction_lfsr.sv - free-running 16-bit Galois LFSR used to randomise the foreperiod
module reaction_lfsr
    import reaction_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Maximal-length taps keep the state out of zero once seeded non-zero.
    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q[0]) begin
            lfsr_d = (lfsr_q >> 1) ^ LFSR_TAPS;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/reaction_trial_scheduler.sv
// rtl/reaction_trial_scheduler.sv - best-of-N reaction session sequencer driving the timer and display
module reaction_trial_scheduler
    import reaction_pkg::*;
#(
    parameter int TIME_W           = TIME_W_DEFAULT,
    parameter int TRIALS_LOG2      = 2,
    parameter int DELAY_MIN_MS     = 1000,
    parameter int DELAY_RANGE_LOG2 = 11,
    parameter int ERR_HOLD_MS      = 1000,
    parameter int TIMEOUT_MS       = 9999
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   ms_tick,
    input  logic                   go_btn,
    input  logic                   react_btn,
    input  logic                   show_best,
    input  logic [TIME_W-1:0]      elapsed_time,
    output logic                   start_timer,
    output logic                   stop_timer,
    output logic                   reset_timer,
    output logic                   go_led,
    output logic                   done,
    output logic                   show_error,
    output logic [TIME_W-1:0]      disp_value,
    output logic [TRIALS_LOG2-1:0] trial_idx
);

    // One down-counter serves both the foreperiod and the error hold time.
    localparam int CNT_W = $clog2(max_int(DELAY_MIN_MS + (1 << DELAY_RANGE_LOG2), ERR_HOLD_MS + 1));
    localparam int SUM_W = TIME_W + TRIALS_LOG2;

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [TRIALS_LOG2-1:0] trial_q;
    logic [SUM_W-1:0]       sum_q;
    logic [TIME_W-1:0]      best_q;
    logic [TIME_W-1:0]      result_q;
    logic                   start_q;
    logic                   reset_tmr_q;
    logic                   go_led_q;
    logic                   done_q;
    logic                   err_q;

    logic [15:0]            lfsr;
    logic                   timeout;
    logic                   go_exit;
    logic [TIME_W-1:0]      go_value;

    reaction_lfsr u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .lfsr_o  (lfsr)
    );

    assign timeout  = elapsed_time >= TIME_W'(TIMEOUT_MS);
    // The first GO cycle carries start_timer, so stop is held off to keep the pulses disjoint.
    assign go_exit  = (state_q == ST_GO) && !start_q && (react_btn || timeout);
    assign go_value = react_btn ? elapsed_time : TIME_W'(TIMEOUT_MS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            trial_q     <= '0;
            sum_q       <= '0;
            best_q      <= '1;
            result_q    <= '0;
            start_q     <= 1'b0;
            reset_tmr_q <= 1'b0;
            go_led_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            start_q     <= 1'b0;
            reset_tmr_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_SUMMARY: begin
                    if (go_btn) begin
                        sum_q       <= '0;
                        best_q      <= '1;
                        trial_q     <= '0;
                        result_q    <= '0;
                        done_q      <= 1'b0;
                        reset_tmr_q <= 1'b1;
                        state_q     <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    cnt_q   <= CNT_W'(DELAY_MIN_MS) + CNT_W'(lfsr[DELAY_RANGE_LOG2-1:0]);
                    state_q <= ST_WAIT_DELAY;
                end
                ST_WAIT_DELAY: begin
                    if (react_btn) begin
                        cnt_q   <= CNT_W'(ERR_HOLD_MS);
                        err_q   <= 1'b1;
                        state_q <= ST_ERROR;
                    end else if (ms_tick) begin
                        if (cnt_q == CNT_W'(1)) begin
                            start_q  <= 1'b1;
                            go_led_q <= 1'b1;
                            state_q  <= ST_GO;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                end
                ST_GO: begin
                    if (go_exit) begin
                        result_q <= go_value;
                        go_led_q <= 1'b0;
                        state_q  <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    sum_q <= sum_q + SUM_W'(result_q);
                    if (result_q < best_q) begin
                        best_q <= result_q;
                    end
                    if (trial_q == '1) begin
                        done_q  <= 1'b1;
                        state_q <= ST_SUMMARY;
                    end else begin
                        trial_q     <= trial_q + TRIALS_LOG2'(1);
                        reset_tmr_q <= 1'b1;
                        state_q     <= ST_ARM;
                    end
                end
                ST_ERROR: begin
                    if (ms_tick) begin
                        if (cnt_q == CNT_W'(1)) begin
                            err_q       <= 1'b0;
                            reset_tmr_q <= 1'b1;
                            state_q     <= ST_ARM;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        disp_value = result_q;
        case (state_q)
            ST_IDLE:    disp_value = '0;
            ST_GO:      disp_value = elapsed_time;
            ST_SUMMARY: disp_value = show_best ? best_q : TIME_W'(sum_q >> TRIALS_LOG2);
            default:    disp_value = result_q;
        endcase
    end

    assign start_timer = start_q;
    assign stop_timer  = go_exit;
    assign reset_timer = reset_tmr_q;
    assign go_led      = go_led_q;
    assign done        = done_q;
    assign show_error  = err_q;
    assign trial_idx   = trial_q;

endmodule
